wb_uart_tx: RTL
===============

Name: wb_uart_tx

Overview:
Wishbone slave peripheral instantiated inside the user project, directly downstream of the wrapper's management-SoC Wishbone port (wbs_*), driving one user IO pad.
- Accepts bytes through memory-mapped registers.
- Buffers them in a small FIFO.
- Serialises them as 8N1 UART frames on tx_o, with a programmable baud divisor.
- Raises an interrupt when the transmitter drains.

Parameters:
- BASE_ADDR, 32'h3000_0000: register block base; decode compares wbs_adr_i[31:4] to BASE_ADDR[31:4].
- FIFO_DEPTH, 8: TX FIFO entries; power of two, 2..16.
- DIV_W, 16: baud divisor width.
- DIV_RST, 103: divisor reset value.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- tx_o  out  1  serial output; idles high.
- tx_oeb_o  out  1  pad output-enable, active low; equals ~CTRL.en.
- irq_o  out  1  level interrupt.

Behaviour:
Reset values: wbs_ack_o=0, wbs_dat_o=0, tx_o=1, tx_oeb_o=1, irq_o=0, FIFO empty, overflow=0, DIV=DIV_RST, CTRL=0, FSM=IDLE.

Register map (offset = adr[3:2]*4):
- 0x0 DATA: write pushes wbs_dat_i[7:0] when sel[0]=1. Read returns 0.
- 0x4 STATUS: read only, except bit3 is W1C.
  - bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bit3 overflow (sticky).
  - bits[12:8] FIFO count.
- 0x8 DIV: RW, bits[DIV_W-1:0]; byte-lane writes honour sel.
- 0xC CTRL: RW. bit0 en, bit1 irq_en.

Wishbone handshake:
- hit = stb & cyc & address match & !wbs_ack_o.
- wbs_ack_o asserts the cycle after hit, for exactly one cycle, so a held strobe acks every other cycle.
- Register write, or FIFO push, takes effect on the hit cycle edge.
- wbs_dat_o is registered with ack and is 0 when not acking.
- No address match: no ack, no side effect.

FIFO:
- Circular buffer with wrap-around pointers and a count.
- Push while full with no same-cycle pop: byte dropped, overflow set.
- Push and pop in the same cycle: both succeed and the count is unchanged, including at full or empty. A push when empty and a pop the same cycle cannot occur, because pop requires !empty.
- Overflow: a W1C in the same cycle as a new overflow leaves overflow set.

Transmit FSM (IDLE, START, DATA, STOP):
- IDLE: if en & !empty, pop the head into the shift register, latch DIV into the bit period (P = DIV+1 cycles), go to START.
- START: tx_o=0 for P cycles.
- DATA: 8 bits, LSB first, P cycles each.
- STOP: tx_o=1 for P cycles, then IDLE.
- Back-to-back frames: a new start bit begins the cycle after STOP ends, with no idle gap.
- en cleared mid-frame: the current frame completes; no new pop.
- DIV written mid-frame: takes effect at the next frame.
- DIV=0 gives a 1-cycle bit period.
- tx_o is registered.

Interrupt: irq_o (registered) = irq_en & empty & FSM==IDLE.

Reset mid-frame: tx_o returns high immediately (async); FIFO contents are discarded.

Decomposition:
- Shared package uart_pkg: register offset constants, STATUS bit indices, FSM state enum.
- One sub-module, wb_uart_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised depth and width.
- Register decode and FSM live in wb_uart_tx.

Test Plan:
1. Reset → tx_o=1, tx_oeb_o=1, STATUS read=0x0000_0002, DIV read=103, wbs_ack_o pulses exactly one cycle after stb.
2. DIV=3, CTRL=1, write 0x55 to DATA → tx_o low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; busy=1 during the frame.
3. CTRL=0, push 9 bytes → STATUS full=1, count=8, overflow=1. W1C bit3 → overflow=0. Set en → all 8 bytes sent in order, back-to-back frames with no gap.
4. CTRL=3, DIV=0, push 0xA5 → irq_o drops the cycle after the push, re-asserts the cycle after STOP completes; frame is 10 cycles long.
5. Assert wb_rst_i mid-DATA → tx_o=1 the same cycle. After release: STATUS empty, count=0, no further start bit.
6. Access to BASE_ADDR+0x40 → no ack, no state change. Push when full concurrent with an FSM pop → count stays 8, overflow stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the Wishbone UART transmitter.
// Holds the register word offsets (wbs_adr_i[3:2]), the STATUS and CTRL bit
// positions, and the transmit FSM state encoding.
package uart_pkg;

    // Register word offsets, compared against wbs_adr_i[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions; the FIFO count occupies bits [12:8]
    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/wb_uart_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   push, wdata   write request and data; accepted when not full or when a
//                 pop happens in the same cycle
//   pop, rdata    read request; rdata always shows the head entry
//   full, empty   occupancy flags
//   count         number of stored entries, 0..DEPTH
module wb_uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot, so a push at full still lands
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // DEPTH is a power of two, so the count MSB is set only when full
    assign full  = count[AW];
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage carries no reset; discarding contents only needs the pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-mapped 8N1 UART transmitter with a TX FIFO and drain interrupt.
// Ports:
//   wb_clk_i, wb_rst_i     clock and asynchronous active-high reset
//   wbs_*                  Wishbone slave: strobe, cycle, write enable, byte
//                          selects, write data, byte address, ack, read data
//   tx_o                   registered serial output, idles high
//   tx_oeb_o               pad output enable, active low (~CTRL.en)
//   irq_o                  level interrupt: irq_en & FIFO empty & FSM idle
// Registers: 0x0 DATA (push), 0x4 STATUS (bit3 W1C), 0x8 DIV, 0xC CTRL.
module wb_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          DIV_W      = 16,
    parameter int          DIV_RST    = 103
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        tx_o,
    output logic        tx_oeb_o,
    output logic        irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             hit;
    logic             bus_wr;
    logic [1:0]       reg_sel;
    logic [31:0]      status_word;
    logic [31:0]      rd_word;
    logic [DIV_W-1:0] div_q;
    logic             ctrl_en;
    logic             ctrl_irq_en;
    logic             ovf_q;
    logic             ovf_set;
    logic             ovf_clr;

    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    tx_state_t        state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic             tx_q, tx_d;
    logic             irq_q;
    logic             bit_done;
    logic             load_frame;

    logic             unused_ok;
    assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

    // The !ack term makes a held strobe complete every other cycle
    assign hit = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o
               & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign bus_wr  = hit & wbs_we_i;
    assign reg_sel = wbs_adr_i[3:2];

    assign fifo_push = bus_wr & (reg_sel == REG_DATA) & wbs_sel_i[0];
    assign ovf_set   = fifo_push & fifo_full & ~fifo_pop;
    assign ovf_clr   = bus_wr & (reg_sel == REG_STATUS) & wbs_sel_i[0]
                     & wbs_dat_i[STAT_OVF];

    wb_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wbs_dat_i[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status_word                          = '0;
        status_word[STAT_FULL]               = fifo_full;
        status_word[STAT_EMPTY]              = fifo_empty;
        status_word[STAT_BUSY]               = (state_q != TX_IDLE);
        status_word[STAT_OVF]                = ovf_q;
        status_word[STAT_CNT_LSB +: CW]      = fifo_count;
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_STATUS: rd_word = status_word;
            REG_DIV:    rd_word[DIV_W-1:0] = div_q;
            REG_CTRL: begin
                rd_word[CTRL_EN]     = ctrl_en;
                rd_word[CTRL_IRQ_EN] = ctrl_irq_en;
            end
            default:    rd_word = '0;
        endcase
    end

    // Bus response and register writes; a new overflow beats a same-cycle W1C
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            div_q       <= DIV_W'(DIV_RST);
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= (hit & ~wbs_we_i) ? rd_word : '0;
            if (bus_wr && reg_sel == REG_DIV) begin
                for (int b = 0; b < DIV_W; b++) begin
                    if (wbs_sel_i[b/8]) begin
                        div_q[b] <= wbs_dat_i[b];
                    end
                end
            end
            if (bus_wr && reg_sel == REG_CTRL && wbs_sel_i[0]) begin
                ctrl_en     <= wbs_dat_i[CTRL_EN];
                ctrl_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            end
            ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
        end
    end

    // Each bit lasts period_q+1 cycles; period is latched once per frame so
    // DIV writes only affect the next frame
    assign bit_done   = (baud_cnt_q == period_q);
    assign load_frame = ctrl_en & ~fifo_empty;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;
        period_d   = period_q;
        fifo_pop   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (load_frame) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_rdata;
                    period_d   = div_q;
                    baud_cnt_d = '0;
                    state_d    = TX_START;
                end
            end
            TX_START: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = TX_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    // Chain straight into the next start bit when data waits
                    if (load_frame) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        period_d = div_q;
                        state_d  = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level follows the next state so tx_o lines up with state_q
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            baud_cnt_q <= '0;
            period_q   <= '0;
            tx_q       <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            period_q   <= period_d;
            tx_q       <= tx_d;
            irq_q      <= ctrl_irq_en & fifo_empty & (state_q == TX_IDLE);
        end
    end

    assign tx_o     = tx_q;
    assign tx_oeb_o = ~ctrl_en;
    assign irq_o    = irq_q;

endmodule
